led_blink_sequencer: RTL and testbench

- Multi-channel LED sequencer: NUM_CH LED outputs share one clock prescaler.
- Each channel is configured through a valid/ready write port to OFF, ON, free-running BLINK, or BURST (N pulses, then off, with a done pulse).
- Sits between a host/config master and board LEDs; replaces per-LED free-running blink counters.

---
 rtl/led_blink_sequencer_if.sv | 25 ++
 rtl/led_blink_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_blink_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
// Configuration write port of the LED sequencer: valid/ready handshake plus
// the channel, mode, phase length and burst count carried with each write.
interface led_blink_sequencer_if #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 4,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [COUNT_W-1:0]  cfg_count;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/led_blink_sequencer.sv
// Multi-channel LED sequencer: one shared tick prescaler drives per-channel
// OFF / ON / BLINK / BURST state machines configured through a write port.
module led_blink_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 10,
  parameter int PERIOD_W = 8,
  parameter int COUNT_W  = 4,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  led_blink_sequencer_if.slave  cfg,
  output logic [NUM_CH-1:0]     led,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    CH_OFF,
    CH_ON,
    CH_BLINK_HI,
    CH_BLINK_LO,
    CH_BURST_HI,
    CH_BURST_LO
  } ch_state_e;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic                tick;
  logic                ready_q, ready_d;
  logic                accept;
  logic [PERIOD_W-1:0] last_cfg;

  ch_state_e           state_q [NUM_CH];
  ch_state_e           state_d [NUM_CH];
  logic [PERIOD_W-1:0] cnt_q   [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d   [NUM_CH];
  logic [PERIOD_W-1:0] last_q  [NUM_CH];
  logic [PERIOD_W-1:0] last_d  [NUM_CH];
  logic [COUNT_W-1:0]  rem_q   [NUM_CH];
  logic [COUNT_W-1:0]  rem_d   [NUM_CH];
  logic [NUM_CH-1:0]   done_q, done_d;

  assign cfg.cfg_ready = ready_q;
  assign done          = done_q;

  always_comb begin
    tick     = (presc_q == PS_W'(TICK_DIV - 1));
    presc_d  = tick ? '0 : presc_q + PS_W'(1);
    ready_d  = 1'b1;
    accept   = cfg.cfg_valid & ready_q;
    // Phase length is kept as P-1 so a zero period behaves as one tick.
    last_cfg = (cfg.cfg_period == '0) ? '0 : cfg.cfg_period - PERIOD_W'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      last_d[i]  = last_q[i];
      rem_d[i]   = rem_q[i];
      done_d[i]  = 1'b0;

      // An accepted write overrides any tick or phase end on the same edge.
      if (accept && (cfg.cfg_ch == CH_W'(i))) begin
        cnt_d[i]  = '0;
        last_d[i] = last_cfg;
        unique case (mode_e'(cfg.cfg_mode))
          MODE_OFF:   state_d[i] = CH_OFF;
          MODE_ON:    state_d[i] = CH_ON;
          MODE_BLINK: state_d[i] = CH_BLINK_HI;
          MODE_BURST: begin
            if (cfg.cfg_count == '0) begin
              state_d[i] = CH_OFF;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = CH_BURST_HI;
              rem_d[i]   = cfg.cfg_count;
            end
          end
        endcase
      end else if (tick && (state_q[i] != CH_OFF) && (state_q[i] != CH_ON)) begin
        if (cnt_q[i] == last_q[i]) begin
          cnt_d[i] = '0;
          unique case (state_q[i])
            CH_BLINK_HI: state_d[i] = CH_BLINK_LO;
            CH_BLINK_LO: state_d[i] = CH_BLINK_HI;
            CH_BURST_HI: state_d[i] = CH_BURST_LO;
            CH_BURST_LO: begin
              rem_d[i] = rem_q[i] - COUNT_W'(1);
              if (rem_q[i] == COUNT_W'(1)) begin
                state_d[i] = CH_OFF;
                done_d[i]  = 1'b1;
              end else begin
                state_d[i] = CH_BURST_HI;
              end
            end
            default: state_d[i] = state_q[i];
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
        end
      end
    end
  end

  always_comb begin
    led  = '0;
    busy = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      led[i]  = (state_q[i] == CH_ON) || (state_q[i] == CH_BLINK_HI) ||
                (state_q[i] == CH_BURST_HI);
      busy[i] = (state_q[i] == CH_BLINK_HI) || (state_q[i] == CH_BLINK_LO) ||
                (state_q[i] == CH_BURST_HI) || (state_q[i] == CH_BURST_LO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      ready_q <= 1'b0;
      done_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_OFF;
        cnt_q[i]   <= '0;
        last_q[i]  <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      presc_q <= presc_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        last_q[i]  <= last_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Scoreboard bench for led_blink_sequencer: a closed-form per-channel model
// predicts outputs after every edge; a monitor compares on the falling edge.
module tb_led_blink_sequencer;

  localparam int NUM_CH   = 5;
  localparam int TICK_DIV = 4;
  localparam int PERIOD_W = 8;
  localparam int COUNT_W  = 4;
  localparam int CH_W     = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] led, busy, done;

  led_blink_sequencer_if #(
    .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W), .CH_W(CH_W)
  ) cfg_if ();

  led_blink_sequencer #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .PERIOD_W(PERIOD_W),
    .COUNT_W(COUNT_W), .CH_W(CH_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg_if),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic              ready;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: mode 0=OFF 1=ON 2=BLINK 3=BURST; ticks counted since accept.
  int m_n;
  int m_mode  [NUM_CH];
  int m_ticks [NUM_CH];
  int m_p     [NUM_CH];
  int m_len   [NUM_CH];

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  initial begin : model
    exp_t e;
    bit   tk, acc;
    int   k;
    m_n = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0; m_ticks[c] = 0; m_p[c] = 1; m_len[c] = 0;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        m_n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          m_mode[c] = 0; m_ticks[c] = 0;
        end
      end else begin
        tk  = (m_n % TICK_DIV) == (TICK_DIV - 1);
        acc = (cfg_if.cfg_valid === 1'b1) && (m_n >= 1);
        e   = '0;
        e.ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (acc && int'(cfg_if.cfg_ch) == c) begin
            m_ticks[c] = 0;
            m_p[c] = (cfg_if.cfg_period == 0) ? 1 : int'(cfg_if.cfg_period);
            m_mode[c] = int'(cfg_if.cfg_mode);
            if (m_mode[c] == 3) begin
              m_len[c] = 2 * m_p[c] * int'(cfg_if.cfg_count);
              if (m_len[c] == 0) begin
                m_mode[c] = 0;
                e.done[c] = 1'b1;
              end
            end
          end else if (tk && m_mode[c] >= 2) begin
            m_ticks[c]++;
            if (m_mode[c] == 3 && m_ticks[c] == m_len[c]) begin
              m_mode[c] = 0;
              e.done[c] = 1'b1;
            end
          end
          k = m_ticks[c] / m_p[c];
          case (m_mode[c])
            1: e.led[c] = 1'b1;
            2, 3: begin
              e.led[c]  = (k % 2) == 0;
              e.busy[c] = 1'b1;
            end
            default: ;
          endcase
        end
        exp_q.push_back(e);
        m_n++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!reset) begin
          chk("cfg_ready", int'(cfg_if.cfg_ready), int'(e.ready));
          chk("led",  int'(led),  int'(e.led));
          chk("busy", int'(busy), int'(e.busy));
          chk("done", int'(done), int'(e.done));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic wr(input int ch, input int mode, input int per, input int cnt);
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(ch);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_period = PERIOD_W'(per);
    cfg_if.cfg_count  = COUNT_W'(cnt);
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_led"},   int'(led),  0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_ready"}, int'(cfg_if.cfg_ready), 0);
  endtask

  initial begin : stim
    int mode;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_mode   = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_count  = '0;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("in_reset");
    #1 reset = 1'b0;
    #1 chk("ready_before_first_edge", int'(cfg_if.cfg_ready), 0);

    wr(0, 2, 2, 0);                 // BLINK P=2
    idle(60);
    wr(1, 3, 1, 3);                 // BURST P=1, three pulses
    idle(40);
    wr(2, 3, 5, 0);                 // BURST count=0: immediate done
    idle(3);
    wr(3, 2, 0, 0);                 // BLINK period=0 toggles every tick
    idle(20);
    wr(1, 3, 3, 5);
    idle(10);
    wr(1, 1, 0, 0);                 // rewrite mid-burst to ON
    idle(30);
    wr(7, 1, 1, 1);                 // out of range channels
    wr(5, 2, 1, 0);
    wr(6, 3, 1, 2);
    idle(10);

    // Align so the write lands on a tick edge where ch3 (P=1) ends a phase.
    for (int k = 0; k < TICK_DIV + 2 && (m_n % TICK_DIV) != (TICK_DIV - 1); k++)
      @(negedge clk);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CH_W'(3);
    cfg_if.cfg_mode   = 2'd2;
    cfg_if.cfg_period = PERIOD_W'(3);
    cfg_if.cfg_count  = '0;
    idle(30);

    wr(4, 2, 255, 0);               // longest supported phase
    idle(2100);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        mode = int'($urandom_range(0, 3));
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = CH_W'($urandom_range(0, 7));
        cfg_if.cfg_mode   = 2'(mode);
        cfg_if.cfg_period = ($urandom_range(0, 19) == 0) ? PERIOD_W'($urandom_range(0, 255))
                                                         : PERIOD_W'($urandom_range(0, 4));
        cfg_if.cfg_count  = COUNT_W'($urandom_range(0, 4));
      end else begin
        cfg_if.cfg_valid  = 1'b0;
      end
    end
    idle(5);

    for (int c = 0; c < NUM_CH; c++) wr(c, 2, 1, 0);
    idle(15);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #1 check_reset_outputs("held_reset");
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("ready_after_rerelease", int'(cfg_if.cfg_ready), 0);
    wr(2, 3, 1, 2);
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
